// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: multi-port register file with busy scoreboard.
//
// Purpose:
//   NRD combinational read ports, two write ports (A: ALU writeback,
//   B: load / multi-cycle writeback, B wins on an address collision),
//   write-to-read bypass, optional hardwired-zero register 0, and a
//   per-register busy scoreboard with an outstanding-write counter so the
//   issue stage can stall on pending multi-cycle results.
//
// Ports:
//   clk, arst                  clock, asynchronous active-high reset
//   wen_a/waddr_a/wdata_a      write port A (never touches busy)
//   wen_b/waddr_b/wdata_b      write port B (clears busy on a busy target)
//   raddr[NRD*ADDR_W]          packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rdata[NRD*DATA_W]          packed read data, same packing
//   rbusy[NRD]                 busy flag per read port
//   sb_set/sb_addr/sb_ack      scoreboard set request and acceptance
//   pend_cnt                   number of busy registers
//   sb_full                    pend_cnt == MAX_PEND
module regfile_mp_sb #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 5,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int MAX_PEND = 4
) (
  input  logic                             clk,
  input  logic                             arst,
  input  logic                             wen_a,
  input  logic [ADDR_W-1:0]                waddr_a,
  input  logic [DATA_W-1:0]                wdata_a,
  input  logic                             wen_b,
  input  logic [ADDR_W-1:0]                waddr_b,
  input  logic [DATA_W-1:0]                wdata_b,
  input  logic [NRD*ADDR_W-1:0]            raddr,
  output logic [NRD*DATA_W-1:0]            rdata,
  output logic [NRD-1:0]                   rbusy,
  input  logic                             sb_set,
  input  logic [ADDR_W-1:0]                sb_addr,
  output logic                             sb_ack,
  output logic [$clog2(MAX_PEND+1)-1:0]    pend_cnt,
  output logic                             sb_full
);

  localparam int N_REG = 1 << ADDR_W;
  localparam int CNT_W = $clog2(MAX_PEND + 1);
  localparam logic ZERO_EN = (ZERO_REG != 0);

  logic [DATA_W-1:0] regs_q [N_REG];
  logic [DATA_W-1:0] regs_d [N_REG];
  logic [N_REG-1:0]  busy_q, busy_d;
  logic [CNT_W-1:0]  pend_cnt_q, pend_cnt_d;

  logic wr_a_ok, wr_b_ok, clr_busy, ack_int, full_int;

  // Register 0 is read-only zero when ZERO_EN; drop writes to it.
  assign wr_a_ok  = wen_a && !(ZERO_EN && (waddr_a == '0));
  assign wr_b_ok  = wen_b && !(ZERO_EN && (waddr_b == '0));
  // Busy is never set on register 0, so no extra zero gating is needed here.
  assign clr_busy = wen_b && busy_q[waddr_b];
  assign full_int = (pend_cnt_q == CNT_W'(MAX_PEND));
  assign ack_int  = sb_set && !full_int && !(ZERO_EN && (sb_addr == '0))
                    && !busy_q[sb_addr];

  always_comb begin
    for (int i = 0; i < N_REG; i++) regs_d[i] = regs_q[i];
    // Port B assigned last so it wins a same-address collision.
    if (wr_a_ok) regs_d[waddr_a] = wdata_a;
    if (wr_b_ok) regs_d[waddr_b] = wdata_b;
  end

  always_comb begin
    busy_d = busy_q;
    // Set and clear can never hit the same address (ack needs !busy,
    // clear needs busy), so their order does not matter.
    if (ack_int)  busy_d[sb_addr] = 1'b1;
    if (clr_busy) busy_d[waddr_b] = 1'b0;
    pend_cnt_d = pend_cnt_q + CNT_W'(ack_int) - CNT_W'(clr_busy);
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int i = 0; i < N_REG; i++) regs_q[i] <= '0;
      busy_q     <= '0;
      pend_cnt_q <= '0;
    end else begin
      for (int i = 0; i < N_REG; i++) regs_q[i] <= regs_d[i];
      busy_q     <= busy_d;
      pend_cnt_q <= pend_cnt_d;
    end
  end

  // Outputs are forced quiet while reset is held, even though the
  // combinational bypass paths would otherwise still be live.
  assign sb_ack   = ack_int && !arst;
  assign sb_full  = full_int && !arst;
  assign pend_cnt = pend_cnt_q;

  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              is_zero;
    logic [DATA_W-1:0] rd_val;

    assign ra      = raddr[gi*ADDR_W +: ADDR_W];
    assign is_zero = ZERO_EN && (ra == '0);

    always_comb begin
      rd_val = regs_q[ra];
      if (wen_a && (waddr_a == ra)) rd_val = wdata_a;
      if (wen_b && (waddr_b == ra)) rd_val = wdata_b;
      if (is_zero || arst)          rd_val = '0;
    end

    assign rdata[gi*DATA_W +: DATA_W] = rd_val;
    // A clearing writeback in flight makes the register look ready now,
    // matching the bypassed rdata.
    assign rbusy[gi] = busy_q[ra] && !(wen_b && (waddr_b == ra))
                       && !is_zero && !arst;
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed testbench for regfile_mp_sb with default parameters.
module tb_regfile_mp_sb;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 5;
  localparam int NRD    = 2;

  logic                     clk = 1'b0;
  logic                     arst;
  logic                     wen_a, wen_b;
  logic [ADDR_W-1:0]        waddr_a, waddr_b;
  logic [DATA_W-1:0]        wdata_a, wdata_b;
  logic [NRD*ADDR_W-1:0]    raddr;
  logic [NRD*DATA_W-1:0]    rdata;
  logic [NRD-1:0]           rbusy;
  logic                     sb_set;
  logic [ADDR_W-1:0]        sb_addr;
  logic                     sb_ack;
  logic [2:0]               pend_cnt;
  logic                     sb_full;

  int checks = 0;
  int errors = 0;

  regfile_mp_sb dut (
    .clk(clk), .arst(arst),
    .wen_a(wen_a), .waddr_a(waddr_a), .wdata_a(wdata_a),
    .wen_b(wen_b), .waddr_b(waddr_b), .wdata_b(wdata_b),
    .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .sb_set(sb_set), .sb_addr(sb_addr), .sb_ack(sb_ack),
    .pend_cnt(pend_cnt), .sb_full(sb_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past a rising edge; inputs change and outputs are sampled
  // a couple of time units later, well away from the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_ra(input int port, input logic [ADDR_W-1:0] a);
    raddr[port*ADDR_W +: ADDR_W] = a;
  endtask

  function automatic logic [DATA_W-1:0] rd(input int port);
    return rdata[port*DATA_W +: DATA_W];
  endfunction

  initial begin
    arst = 1'b1; wen_a = 0; wen_b = 0; waddr_a = 0; waddr_b = 0;
    wdata_a = 0; wdata_b = 0; raddr = '0; sb_set = 0; sb_addr = 0;

    // ---- Reset and zero register ----
    tick();
    wen_a = 1; waddr_a = 5'd5; wdata_a = 16'hCAFE; set_ra(0, 5'd5);
    #1;
    chk("rst_rdata_gated", 32'(rd(0)), 32'h0);
    chk("rst_sb_full", 32'(sb_full), 32'h0);
    chk("rst_pend", 32'(pend_cnt), 32'h0);
    wen_a = 0;
    tick();
    arst = 0;
    tick();
    wen_a = 1; waddr_a = 5'd9; wdata_a = 16'h9999;
    sb_set = 1; sb_addr = 5'd6;
    #1;
    chk("pre_ack6", 32'(sb_ack), 32'h1);
    tick();
    wen_a = 0; sb_set = 0; set_ra(0, 5'd9);
    #1;
    chk("pre_rd9", 32'(rd(0)), 32'h9999);
    chk("pre_pend", 32'(pend_cnt), 32'h1);
    // async reset mid-write
    wen_a = 1; waddr_a = 5'd10; wdata_a = 16'hAAAA; set_ra(1, 5'd10);
    #1;
    chk("pre_bypass10", 32'(rd(1)), 32'hAAAA);
    arst = 1;
    #1;
    chk("arst_rd9", 32'(rd(0)), 32'h0);
    chk("arst_rd10", 32'(rd(1)), 32'h0);
    chk("arst_pend", 32'(pend_cnt), 32'h0);
    wen_a = 0;
    tick();
    arst = 0;
    for (int a = 0; a < 32; a++) begin
      set_ra(0, 5'(a)); set_ra(1, 5'(31 - a));
      #1;
      chk($sformatf("sweep_rd_%0d", a), 32'(rd(0)), 32'h0);
      chk($sformatf("sweep_busy_%0d", a), 32'(rbusy), 32'h0);
    end
    wen_a = 1; waddr_a = 5'd0; wdata_a = 16'hBEEF; set_ra(0, 5'd0);
    #1;
    chk("zero_bypass", 32'(rd(0)), 32'h0);
    tick();
    wen_a = 0;
    #1;
    chk("zero_stored", 32'(rd(0)), 32'h0);
    sb_set = 1; sb_addr = 5'd0;
    #1;
    chk("zero_no_ack", 32'(sb_ack), 32'h0);
    sb_set = 0;

    // ---- Write and bypass ----
    wen_a = 1; waddr_a = 5'd5; wdata_a = 16'h1234; set_ra(0, 5'd5); set_ra(1, 5'd5);
    #1;
    chk("byp_a_p0", 32'(rd(0)), 32'h1234);
    chk("byp_a_p1", 32'(rd(1)), 32'h1234);
    tick();
    wen_a = 0;
    #1;
    chk("stored_5", 32'(rd(0)), 32'h1234);

    // ---- Write conflict ----
    wen_a = 1; waddr_a = 5'd7; wdata_a = 16'h1111;
    wen_b = 1; waddr_b = 5'd7; wdata_b = 16'h2222; set_ra(0, 5'd7);
    #1;
    chk("conflict_byp", 32'(rd(0)), 32'h2222);
    tick();
    wen_a = 0; wen_b = 0;
    #1;
    chk("conflict_stored", 32'(rd(0)), 32'h2222);
    chk("conflict_p1_5", 32'(rd(1)), 32'h1234);

    // ---- Scoreboard fill ----
    for (int a = 1; a <= 4; a++) begin
      sb_set = 1; sb_addr = 5'(a);
      #1;
      chk($sformatf("fill_ack_%0d", a), 32'(sb_ack), 32'h1);
      tick();
      chk($sformatf("fill_pend_%0d", a), 32'(pend_cnt), 32'(a));
    end
    sb_addr = 5'd5; set_ra(0, 5'd3); set_ra(1, 5'd7);
    #1;
    chk("full_flag", 32'(sb_full), 32'h1);
    chk("full_no_ack5", 32'(sb_ack), 32'h0);
    chk("rbusy_3_7", 32'(rbusy), 32'h1);

    // ---- Clear with set while full ----
    wen_b = 1; waddr_b = 5'd2; wdata_b = 16'hAAAA; set_ra(0, 5'd2);
    #1;
    chk("clr_no_ack", 32'(sb_ack), 32'h0);
    chk("clr_rbusy", 32'(rbusy[0]), 32'h0);
    chk("clr_rdata", 32'(rd(0)), 32'hAAAA);
    tick();
    wen_b = 0;
    #1;
    chk("clr_pend", 32'(pend_cnt), 32'h3);
    chk("clr_not_full", 32'(sb_full), 32'h0);
    chk("clr_ack5", 32'(sb_ack), 32'h1);
    chk("clr_stored2", 32'(rd(0)), 32'hAAAA);
    tick();
    sb_set = 0;
    #1;
    chk("refill_pend", 32'(pend_cnt), 32'h4);

    // ---- Duplicate set and port-A write (busy: 1,3,4,5) ----
    wen_b = 1; waddr_b = 5'd4; wdata_b = 16'h4444;
    tick();
    wen_b = 0;
    #1;
    chk("free4_pend", 32'(pend_cnt), 32'h3);
    sb_set = 1; sb_addr = 5'd1;
    wen_a = 1; waddr_a = 5'd1; wdata_a = 16'h5555; set_ra(0, 5'd1);
    #1;
    chk("dup_no_ack", 32'(sb_ack), 32'h0);
    chk("dup_rbusy_byp", 32'(rbusy[0]), 32'h1);
    chk("dup_rdata_byp", 32'(rd(0)), 32'h5555);
    tick();
    sb_set = 0; wen_a = 0;
    #1;
    chk("dup_pend", 32'(pend_cnt), 32'h3);
    chk("dup_rbusy", 32'(rbusy[0]), 32'h1);
    chk("dup_stored", 32'(rd(0)), 32'h5555);

    // wen_b on a non-busy register leaves the count alone
    wen_b = 1; waddr_b = 5'd4; wdata_b = 16'h0404;
    tick();
    wen_b = 0;
    #1;
    chk("nb_clr_pend", 32'(pend_cnt), 32'h3);

    // set and clear on different addresses in one cycle
    sb_set = 1; sb_addr = 5'd6; wen_b = 1; waddr_b = 5'd3; wdata_b = 16'h3333;
    set_ra(0, 5'd6); set_ra(1, 5'd3);
    #1;
    chk("sc_ack6", 32'(sb_ack), 32'h1);
    tick();
    sb_set = 0; wen_b = 0;
    #1;
    chk("sc_pend", 32'(pend_cnt), 32'h3);
    chk("sc_rbusy", 32'(rbusy), 32'h1);
    chk("sc_rd3", 32'(rd(1)), 32'h3333);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised multi-port successor to the datapath register file.
- Provides NRD combinational read ports and two write ports: A for ALU writeback, B for load/multi-cycle writeback.
- Write-to-read bypass and optional hardwired-zero register.
- Per-register busy scoreboard with an outstanding-write counter, so the issue stage can stall on pending multi-cycle results.

Parameters:
- DATA_W, 16, data width in bits.
- ADDR_W, 5, register address width; N_REG = 2**ADDR_W.
- NRD, 2, number of read ports (1..4).
- ZERO_REG, 1. 1: register 0 reads 0, ignores writes, never busy.
- MAX_PEND, 4, maximum simultaneously busy registers (1..N_REG).

Ports:
- clk  in  1  system clock.
- arst  in  1  asynchronous reset, active-high.
- wen_a  in  1  write enable, port A.
- waddr_a  in  ADDR_W  write address, port A.
- wdata_a  in  DATA_W  write data, port A.
- wen_b  in  1  write enable, port B; also clears busy.
- waddr_b  in  ADDR_W  write address, port B.
- wdata_b  in  DATA_W  write data, port B.
- raddr  in  NRD*ADDR_W  packed read addresses; port i at bits [i*ADDR_W +: ADDR_W].
- rdata  out  NRD*DATA_W  packed read data, same packing.
- rbusy  out  NRD  busy flag per read port.
- sb_set  in  1  request to mark sb_addr busy.
- sb_addr  in  ADDR_W  register to mark busy.
- sb_ack  out  1  sb_set accepted this cycle.
- pend_cnt  out  clog2(MAX_PEND+1)  number of busy registers.
- sb_full  out  1  pend_cnt == MAX_PEND.

Behaviour:
- Clocking and reset:
  - Single clock domain; clk and arst only.
  - Reset is asynchronous and active-high.
  - arst=1 clears all registers, all busy bits and pend_cnt to 0.
  - Outputs during reset: rdata = 0, rbusy = 0, sb_ack = 0, sb_full = 0.
  - Reset asserted mid-operation discards pending writes and busy state immediately.
- Writes:
  - Writes land on the rising clk edge.
  - wen_a and wen_b to the same address in the same cycle: port B wins.
  - ZERO_REG=1: writes to address 0 are dropped.
- Reads (combinational, 0-cycle latency):
  - ZERO_REG=1 and raddr_i==0: rdata_i = 0.
  - Else if wen_b && waddr_b==raddr_i: rdata_i = wdata_b.
  - Else if wen_a && waddr_a==raddr_i: rdata_i = wdata_a.
  - Else rdata_i = stored value.
- Scoreboard:
  - busy[N_REG] registered.
  - sb_ack = sb_set && !sb_full && !(ZERO_REG && sb_addr==0) && !busy[sb_addr].
  - Setting an already-busy register is not acked.
  - On sb_ack: busy[sb_addr] is set at the next edge.
  - wen_b with busy[waddr_b]=1 clears busy[waddr_b] at the next edge.
  - Port A writes never touch busy.
  - Set and clear to the same address in one cycle: cannot occur, because sb_ack needs !busy and clear needs busy.
  - Set and clear to different addresses in one cycle: both take effect; pend_cnt is unchanged.
- pend_cnt:
  - Next value = pend_cnt + sb_ack − (wen_b && busy[waddr_b]).
  - Never exceeds MAX_PEND; never wraps below 0.
  - sb_full is decoded combinationally from pend_cnt.
  - When full, sb_set is not acked; a simultaneous clear frees a slot from the next cycle only.
- rbusy:
  - rbusy_i = busy[raddr_i] && !(wen_b && waddr_b==raddr_i).
  - This bypasses the clearing writeback, consistent with rdata.
  - rbusy_i = 0 for address 0 when ZERO_REG=1.

Test Plan:
1. Reset and zero register:
   - Stimulus: pulse arst mid-write; then read all 32 addresses; then wen_a addr0 = 0xBEEF.
   - Required: rdata = 0 everywhere; rdata for addr0 stays 0 after the write.
2. Write and bypass:
   - Stimulus: wen_a addr5 = 0x1234, raddr0 = 5 in the same cycle.
   - Required: rdata0 = 0x1234 combinationally; it still reads 0x1234 after the edge.
3. Write conflict:
   - Stimulus: wen_a = 0x1111 and wen_b = 0x2222, both to addr7.
   - Required: the bypass read and the stored value are both 0x2222.
4. Scoreboard fill:
   - Stimulus: sb_set on addr 1, 2, 3, 4 on consecutive cycles, then addr 5.
   - Required: first four acked; pend_cnt = 4; sb_full = 1; addr5 sb_ack = 0.
   - Required: rbusy = 1 for raddr = 3.
5. Clear with set:
   - Stimulus: while full, wen_b addr2 = 0xAAAA together with sb_set addr5.
   - Required: sb_ack = 0 that cycle; rbusy for addr2 = 0 with rdata = 0xAAAA in the same cycle.
   - Required: next cycle pend_cnt = 3 and sb_set addr5 is acked.
6. Duplicate set and port-A write:
   - Stimulus: sb_set addr1 while addr1 is busy; wen_a addr1 = 0x5555.
   - Required: sb_ack = 0; busy[1] stays 1; pend_cnt unchanged.
